// File: rtl/alu_uart_if.sv
// Bundle of UART/ALU-side signals for alu_uart_interface.
// The slave modport is the sequencer's view; master is the environment's view.
interface alu_uart_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_alu_data_A;
    logic [NB_DATA-1:0] o_alu_data_B;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic [2:0]         o_state;

    modport slave (
        input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        output o_alu_data_A, o_alu_data_B, o_alu_op, o_tx_data, o_tx_start, o_state
    );

    modport master (
        output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        input  o_alu_data_A, o_alu_data_B, o_alu_op, o_tx_data, o_tx_start, o_state
    );
endinterface

// File: rtl/alu_uart_interface.sv
// Collects A, B and opcode bytes from the UART, presents them to the ALU,
// then hands the ALU result to the transmitter with a one-cycle start pulse.
module alu_uart_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 1000000
) (
    input logic      i_clk,
    input logic      i_reset,
    alu_uart_if.slave bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_A       = 3'd0,
        ST_B       = 3'd1,
        ST_OP      = 3'd2,
        ST_START   = 3'd3,
        ST_WAIT_TX = 3'd4
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [NB_DATA-1:0] alu_a;
    logic [NB_DATA-1:0] alu_b;
    logic [NB_OP-1:0]   alu_op;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_start;

    // Handshake: an input byte exists only in a cycle with i_rx_done=1; the
    // transmitter owns o_tx_data from the o_tx_start cycle until i_tx_done.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_A;
            cnt      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_A: begin
                    cnt <= '0;
                    if (bus.i_rx_done) begin
                        alu_a <= bus.i_rx_data;
                        state <= ST_B;
                    end
                end
                ST_B: begin
                    // An arriving byte beats the timeout in the same cycle.
                    if (bus.i_rx_done) begin
                        alu_b <= bus.i_rx_data;
                        cnt   <= '0;
                        state <= ST_OP;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= ST_A;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_OP: begin
                    if (bus.i_rx_done) begin
                        alu_op <= bus.i_rx_data[NB_OP-1:0];
                        cnt    <= '0;
                        state  <= ST_START;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= ST_A;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_START: begin
                    cnt      <= '0;
                    tx_data  <= bus.i_alu_result;
                    tx_start <= 1'b1;
                    state    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    cnt <= '0;
                    if (bus.i_tx_done) state <= ST_A;
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_A;
                end
            endcase
        end
    end

    assign bus.o_alu_data_A = alu_a;
    assign bus.o_alu_data_B = alu_b;
    assign bus.o_alu_op     = alu_op;
    assign bus.o_tx_data    = tx_data;
    assign bus.o_tx_start   = tx_start;
    assign bus.o_state      = state;
endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed scoreboard bench for alu_uart_interface with a small ALU model
// feeding i_alu_result from the registered operands.
module tb_alu_uart_interface;
    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TIMEOUT = 16;
    localparam int EW      = 3 * NB_DATA + NB_OP;

    localparam logic [2:0] S_A     = 3'd0;
    localparam logic [2:0] S_OP    = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   pulses_seen;
    int   pulses_expected;
    logic prev_start;
    logic [EW-1:0] exp_q[$];

    alu_uart_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

    alu_uart_interface #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT(TIMEOUT)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: undefined opcodes return 0
    always_comb begin
        bus.i_alu_result = '0;
        case (bus.o_alu_op)
            6'h20: bus.i_alu_result = bus.o_alu_data_A + bus.o_alu_data_B;
            6'h22: bus.i_alu_result = bus.o_alu_data_A - bus.o_alu_data_B;
            6'h24: bus.i_alu_result = bus.o_alu_data_A & bus.o_alu_data_B;
            6'h25: bus.i_alu_result = bus.o_alu_data_A | bus.o_alu_data_B;
            6'h26: bus.i_alu_result = bus.o_alu_data_A ^ bus.o_alu_data_B;
            6'h27: bus.i_alu_result = ~(bus.o_alu_data_A | bus.o_alu_data_B);
            6'h03: bus.i_alu_result = NB_DATA'($signed(bus.o_alu_data_A) >>> bus.o_alu_data_B);
            6'h02: bus.i_alu_result = bus.o_alu_data_A >> bus.o_alu_data_B;
            default: bus.i_alu_result = '0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(posedge clk); #1;
        bus.i_rx_done = 1'b0;
    endtask

    task automatic expect_txn(input logic [7:0] a, input logic [7:0] b,
                              input logic [5:0] op, input logic [7:0] res);
        exp_q.push_back({a, b, op, res});
        pulses_expected++;
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int n;
        n = 0;
        while (bus.o_state !== s && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: timed out, state 0x%0h expected 0x%0h", name, bus.o_state, s);
        end
    endtask

    task automatic finish_tx(input string name);
        wait_state(S_WAIT, name);
        bus.i_tx_done = 1'b1;
        @(posedge clk); #1;
        bus.i_tx_done = 1'b0;
        check({name, "_idle"}, 32'(bus.o_state), 32'(S_A));
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                       input logic [7:0] res, input string name);
        expect_txn(a, b, opb[5:0], res);
        send_byte(a);
        send_byte(b);
        send_byte(opb);
        finish_tx(name);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_tx_start) begin
                pulses_seen++;
                if (prev_start) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL start_width: o_tx_start high 2 cycles, got 1 expected 0");
                end
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL spurious_start: tx_data 0x%0h, expected no o_tx_start", bus.o_tx_data);
                end else begin
                    logic [EW-1:0] e;
                    logic [EW-1:0] act;
                    e = exp_q.pop_front();
                    act = {bus.o_alu_data_A, bus.o_alu_data_B, bus.o_alu_op, bus.o_tx_data};
                    tests_run++;
                    if (act !== e) begin
                        tests_failed++;
                        $display("FAIL txn: {A,B,op,tx_data} got 0x%0h expected 0x%0h", act, e);
                    end
                end
            end
            prev_start = bus.o_tx_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    initial begin
        tests_run = 0;
        tests_failed = 0;
        pulses_seen = 0;
        pulses_expected = 0;
        prev_start = 1'b0;
        rst = 1'b1;
        bus.i_rx_data = '0;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_A", 32'(bus.o_alu_data_A), 32'h0);
        check("rst_B", 32'(bus.o_alu_data_B), 32'h0);
        check("rst_op", 32'(bus.o_alu_op), 32'h0);
        check("rst_tx_data", 32'(bus.o_tx_data), 32'h0);
        check("rst_tx_start", 32'(bus.o_tx_start), 32'h0);
        check("rst_state", 32'(bus.o_state), 32'(S_A));

        // ADD with latency check; i_tx_done given in the o_tx_start cycle
        expect_txn(8'h05, 8'h03, 6'h20, 8'h08);
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        check("lat_state_start", 32'(bus.o_state), 32'(S_START));
        check("lat_start_n1", 32'(bus.o_tx_start), 32'h0);
        check("lat_op", 32'(bus.o_alu_op), 32'h20);
        @(posedge clk); #1;
        check("lat_start_n2", 32'(bus.o_tx_start), 32'h1);
        check("lat_tx_data", 32'(bus.o_tx_data), 32'h08);
        bus.i_tx_done = 1'b1;
        @(posedge clk); #1;
        bus.i_tx_done = 1'b0;
        check("add_idle", 32'(bus.o_state), 32'(S_A));
        check("hold_A", 32'(bus.o_alu_data_A), 32'h05);
        check("hold_B", 32'(bus.o_alu_data_B), 32'h03);

        txn(8'h03, 8'h05, 8'h22, 8'hFE, "sub");
        txn(8'h81, 8'h01, 8'h03, 8'hC0, "sra");
        txn(8'hF0, 8'h0F, 8'hE7, 8'h00, "nor");
        txn(8'h11, 8'h22, 8'h3F, 8'h00, "undef");

        // bytes arriving during ST_START and ST_WAIT_TX are dropped
        expect_txn(8'h01, 8'h02, 6'h25, 8'h03);
        send_byte(8'h01);
        send_byte(8'h02);
        @(posedge clk); #1;
        bus.i_rx_data = 8'h25;
        bus.i_rx_done = 1'b1;
        @(posedge clk); #1;
        bus.i_rx_data = 8'hAA;
        @(posedge clk); #1;
        bus.i_rx_data = 8'hBB;
        @(posedge clk); #1;
        bus.i_rx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        finish_tx("drop");
        txn(8'h01, 8'h01, 8'h20, 8'h02, "after_drop");

        // timeout after A, then fresh transaction
        send_byte(8'h09);
        repeat (TIMEOUT) @(posedge clk);
        #1;
        check("timeout_state", 32'(bus.o_state), 32'(S_A));
        check("timeout_keep_A", 32'(bus.o_alu_data_A), 32'h09);
        txn(8'h07, 8'h02, 8'h22, 8'h05, "post_timeout");

        // byte on the last idle cycle is still accepted as B
        expect_txn(8'h0A, 8'h04, 6'h22, 8'h06);
        send_byte(8'h0A);
        repeat (TIMEOUT - 2) @(posedge clk);
        send_byte(8'h04);
        check("edge_state", 32'(bus.o_state), 32'(S_OP));
        check("edge_B", 32'(bus.o_alu_data_B), 32'h04);
        send_byte(8'h22);
        finish_tx("edge");

        // reset while in ST_OP
        send_byte(8'h33);
        send_byte(8'h44);
        check("pre_rst_state", 32'(bus.o_state), 32'(S_OP));
        pulse_reset();
        check("rst_op_A", 32'(bus.o_alu_data_A), 32'h0);
        check("rst_op_B", 32'(bus.o_alu_data_B), 32'h0);
        check("rst_op_state", 32'(bus.o_state), 32'(S_A));
        txn(8'h06, 8'h03, 8'h26, 8'h05, "fresh1");

        // reset while in ST_WAIT_TX
        expect_txn(8'h10, 8'h20, 6'h25, 8'h30);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h25);
        wait_state(S_WAIT, "rst_wait");
        pulse_reset();
        check("rst_wait_tx_data", 32'(bus.o_tx_data), 32'h0);
        check("rst_wait_tx_start", 32'(bus.o_tx_start), 32'h0);
        check("rst_wait_op", 32'(bus.o_alu_op), 32'h0);
        check("rst_wait_state", 32'(bus.o_state), 32'(S_A));
        repeat (4) @(posedge clk);
        txn(8'h0C, 8'h0A, 8'h24, 8'h08, "fresh2");

        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        check("pulse_count", 32'(pulses_seen), 32'(pulses_expected));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
